// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the VGA frame streamer: default visible
//               geometry, frame size, address width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;   // 307200

    localparam int ADDR_W       = 19;
    localparam int STATE_W      = 2;

    // Streamer FSM encoding
    localparam logic [STATE_W-1:0] c_ST_IDLE   = 2'd0;  // waiting for first frame sync
    localparam logic [STATE_W-1:0] c_ST_ARMED  = 2'd1;  // synced, no pixel seen yet
    localparam logic [STATE_W-1:0] c_ST_ACTIVE = 2'd2;  // frame in progress

    // Frame sync is the overlap of the two active-low sync pulses.
    function automatic logic is_frame_sync(input logic hs, input logic vs);
        return ~hs & ~vs;
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay_line
// Description : Fixed-depth shift register used to align sync/blank signals
//               with the pixel data pipeline.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset, loads RESET_VAL
//               i_d  - input word
//               o_q  - input word delayed by DEPTH cycles
// Revision    : 1.0 - initial release
// ============================================================================
module sync_delay_line #(
    parameter int                WIDTH     = 3,
    parameter int                DEPTH     = 3,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule : sync_delay_line
`default_nettype wire

// File: rtl/vga_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_streamer
// Description : Generates background-memory pixel addresses from the VGA
//               sync/blank timing, tracks frame completeness, and drives the
//               DAC colour and delayed sync outputs aligned to the pixel
//               data returned PIPE_LAT cycles after each address.
// Ports       : clk, rst          - pixel clock, sync active-high reset
//               hs, vs, blank_n   - timing from the sync generator
//               bgr_in            - overlaid pixel {B,G,R}
//               addr              - background memory pixel address
//               vga_r/g/b         - DAC colour (zero while blanked)
//               vga_hs/vs/blank_n - timing delayed by PIPE_LAT+1
//               frame_done        - one-cycle pulse when a frame closes
//               frame_count       - completed frames (saturating)
//               frame_error       - last closed frame had wrong pixel count
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_streamer #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank_n,
    input  logic [23:0] bgr_in,
    output logic [18:0] addr,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        frame_error
);

    import vga_pkg::*;

    localparam int                c_FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] c_FRAME_CNT    = ADDR_W'(c_FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR    = ADDR_W'(c_FRAME_PIXELS - 1);
    localparam int                c_DELAY        = PIPE_LAT + 1;

    // ------------------------------------------------------------------
    // Address generation and frame accounting
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_pixel_cnt;
    logic               r_overlong;
    logic               r_frame_done;
    logic [15:0]        r_frame_count;
    logic               r_frame_error;

    logic w_frame_sync;
    logic w_addr_last;
    logic w_cnt_sat;
    logic w_cnt_full;

    assign w_frame_sync = is_frame_sync(hs, vs);
    assign w_addr_last  = (r_addr == c_LAST_ADDR);
    assign w_cnt_sat    = &r_pixel_cnt;
    // A visible pixel arriving once a whole frame has been counted is extra.
    assign w_cnt_full   = (r_pixel_cnt >= c_FRAME_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_addr        <= '0;
            r_pixel_cnt   <= '0;
            r_overlong    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_addr <= '0;
                    if (w_frame_sync) begin
                        r_state <= c_ST_ARMED;
                    end
                end

                c_ST_ARMED, c_ST_ACTIVE: begin
                    // Sync wins over a coincident visible pixel.
                    if (w_frame_sync) begin
                        r_addr  <= '0;
                        r_state <= c_ST_ARMED;
                        // Only a frame that saw pixels closes; a held sync
                        // falls into ARMED after its first cycle.
                        if (r_state == c_ST_ACTIVE) begin
                            r_frame_done  <= 1'b1;
                            r_frame_error <= (r_pixel_cnt != c_FRAME_CNT) || r_overlong;
                            if (r_frame_count != 16'hFFFF) begin
                                r_frame_count <= r_frame_count + 16'd1;
                            end
                            r_pixel_cnt <= '0;
                            r_overlong  <= 1'b0;
                        end
                    end else if (blank_n) begin
                        r_state <= c_ST_ACTIVE;
                        r_addr  <= w_addr_last ? '0 : r_addr + 19'd1;
                        if (w_cnt_full) begin
                            r_overlong <= 1'b1;
                        end
                        if (!w_cnt_sat) begin
                            r_pixel_cnt <= r_pixel_cnt + 19'd1;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign addr        = r_addr;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign frame_error = r_frame_error;

    // ------------------------------------------------------------------
    // Video path: timing delayed to meet the returning pixel data
    // ------------------------------------------------------------------
    logic [2:0]  w_sync_dly;
    logic [23:0] r_bgr;

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (c_DELAY),
        .RESET_VAL (3'b110)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .i_d ({hs, vs, blank_n}),
        .o_q (w_sync_dly)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bgr <= '0;
        end else begin
            r_bgr <= bgr_in;
        end
    end

    assign vga_hs      = w_sync_dly[2];
    assign vga_vs      = w_sync_dly[1];
    assign vga_blank_n = w_sync_dly[0];

    assign vga_b = w_sync_dly[0] ? r_bgr[23:16] : 8'h00;
    assign vga_g = w_sync_dly[0] ? r_bgr[15:8]  : 8'h00;
    assign vga_r = w_sync_dly[0] ? r_bgr[7:0]   : 8'h00;

endmodule : vga_frame_streamer
`default_nettype wire

// File: tb/tb_vga_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_streamer
// Description : Self-checking bench for vga_frame_streamer using a scaled
//               raster (16x8 visible inside 24x12 total) so full frames stay
//               short. A behavioural model predicts every output each cycle;
//               directed literal checks pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_streamer;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int LAT   = 2;
    localparam int FRAME = H * V;
    localparam int H_TOT = 24;
    localparam int V_TOT = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        blank_n = 1'b0;
    logic [23:0] bgr_in = '0;
    logic [18:0] addr;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        frame_error;

    vga_frame_streamer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .PIPE_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hs          (hs),
        .vs          (vs),
        .blank_n     (blank_n),
        .bgr_in      (bgr_in),
        .addr        (addr),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .frame_error (frame_error)
    );

    always #20 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int max_vis_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit          m_started = 0;
    bit          m_synced;      // a frame sync has been seen since reset
    bit          m_in_frame;    // visible pixels seen since last sync
    int          m_pix;
    bit          m_over;
    int          m_addr;
    bit          m_done;
    int          m_count;
    bit          m_err;
    logic [23:0] m_bgr;
    logic [2:0]  dq[$];         // {hs,vs,blank_n} history, oldest at front

    always @(posedge clk) begin
        if (rst) begin
            m_synced = 0; m_in_frame = 0; m_pix = 0; m_over = 0;
            m_addr = 0; m_done = 0; m_count = 0; m_err = 0; m_bgr = '0;
            dq.delete();
            repeat (LAT + 1) dq.push_back(3'b110);
        end else begin
            m_done = 0;
            if (!m_synced) begin
                m_addr = 0;
                if (!hs && !vs) m_synced = 1;
            end else if (!hs && !vs) begin
                if (m_in_frame) begin
                    m_done  = 1;
                    m_err   = (m_pix != FRAME) || m_over;
                    m_count = (m_count < 65535) ? m_count + 1 : m_count;
                end
                m_in_frame = 0; m_pix = 0; m_over = 0; m_addr = 0;
            end else if (blank_n) begin
                m_in_frame = 1;
                if (m_pix >= FRAME) m_over = 1;
                m_pix++;
                m_addr = (m_addr + 1) % FRAME;
            end
            dq.push_back({hs, vs, blank_n});
            void'(dq.pop_front());
            m_bgr = bgr_in;
        end
        m_started = 1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("addr",        addr,        m_addr);
            check("frame_done",  frame_done,  m_done);
            check("frame_count", frame_count, m_count);
            check("frame_error", frame_error, m_err);
            check("vga_hs",      vga_hs,      dq[0][2]);
            check("vga_vs",      vga_vs,      dq[0][1]);
            check("vga_blank_n", vga_blank_n, dq[0][0]);
            check("vga_bgr",     {vga_b, vga_g, vga_r}, dq[0][0] ? m_bgr : 24'h0);
            if (frame_done === 1'b1) done_seen++;
            if (blank_n && int'(addr) > max_vis_addr) max_vis_addr = int'(addr);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus primitives: inputs change 1 time unit after the edge
    // ------------------------------------------------------------------
    task automatic drive(input logic h, input logic v, input logic b, input logic [23:0] px);
        hs = h; vs = v; blank_n = b; bgr_in = px;
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b1, 24'($urandom));
    endtask

    task automatic blanks(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0, 24'($urandom));
    endtask

    task automatic syncs(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 24'($urandom));
    endtask

    // Scaled raster: visible first, hsync at x 18..20, vsync on lines 9..10.
    task automatic run_frame();
        for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
                drive(!(x >= H + 2 && x <= H + 4),
                      !(y >= V + 1 && y <= V + 2),
                      (y < V && x < H),
                      24'($urandom));
            end
        end
    endtask

    int d0;

    initial begin
        // Reset
        blanks(3);
        check("rst_addr",        addr,        0);
        check("rst_frame_count", frame_count, 0);
        check("rst_frame_done",  frame_done,  0);
        check("rst_frame_error", frame_error, 0);
        check("rst_vga_sync",    {vga_hs, vga_vs, vga_blank_n}, 3'b110);
        check("rst_rgb",         {vga_b, vga_g, vga_r}, 0);
        rst = 1'b0;

        // First raster only arms the streamer; second is a complete frame
        run_frame();
        run_frame();
        check("full_done_pulses", done_seen,    1);
        check("full_count",       frame_count,  1);
        check("full_error",       frame_error,  0);
        check("full_max_addr",    max_vis_addr, FRAME - 1);

        // Colour alignment and blanking
        blanks(1);
        pixels(1);
        for (int i = 1; i < LAT; i++) blanks(1);
        drive(1'b1, 1'b1, 1'b0, 24'hFF8040);
        check("color_b", vga_b, 8'hFF);
        check("color_g", vga_g, 8'h80);
        check("color_r", vga_r, 8'h40);
        check("color_blank_n", vga_blank_n, 1);
        drive(1'b1, 1'b1, 1'b0, 24'hFFFFFF);
        check("blank_rgb", {vga_b, vga_g, vga_r}, 0);

        // Truncated frame: 40 pixels then early sync
        pixels(39);
        d0 = done_seen;
        syncs(1);
        check("trunc_done",  frame_done,  1);
        check("trunc_error", frame_error, 1);
        check("trunc_count", frame_count, 2);
        syncs(2);
        blanks(3);
        check("trunc_single_pulse", done_seen - d0, 1);
        run_frame();
        check("recover_error", frame_error, 0);
        check("recover_count", frame_count, 3);

        // Reset mid-frame
        pixels(50);
        check("mid_addr", addr, 50);
        d0 = done_seen;
        rst = 1'b1;
        blanks(1);
        rst = 1'b0;
        check("midrst_addr",  addr,        0);
        check("midrst_done",  frame_done,  0);
        check("midrst_count", frame_count, 0);
        check("midrst_error", frame_error, 0);
        check("midrst_sync",  {vga_hs, vga_vs, vga_blank_n}, 3'b110);
        check("midrst_rgb",   {vga_b, vga_g, vga_r}, 0);
        pixels(5);
        check("idle_ignores_blank", addr, 0);
        check("midrst_no_pulse", done_seen - d0, 0);

        // Overlong frame: FRAME+1 pixels
        syncs(1);
        pixels(FRAME - 1);
        check("over_last_addr", addr, FRAME - 1);
        pixels(1);
        check("over_wrap_addr", addr, 0);
        pixels(1);
        check("over_extra_addr", addr, 1);
        syncs(1);
        check("over_done",  frame_done,  1);
        check("over_error", frame_error, 1);
        check("over_count", frame_count, 1);
        blanks(2);

        // Full frame closed by a sync coincident with blank_n, held 96 cycles
        pixels(FRAME);
        d0 = done_seen;
        drive(1'b0, 1'b0, 1'b1, 24'($urandom));
        check("coin_done",  frame_done,  1);
        check("coin_addr",  addr,        0);
        check("coin_error", frame_error, 0);
        repeat (95) drive(1'b0, 1'b0, 1'b1, 24'($urandom));
        blanks(2);
        check("held_single_pulse", done_seen - d0, 1);
        check("held_addr",  addr,        0);
        check("held_count", frame_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_vga_frame_streamer
`default_nettype wire
